// File: rtl/num_smul_pipe.sv
// num_smul_pipe: fully pipelined signed fixed-point multiplier with
// output windowing, round-half-up, saturation and overflow flag.
module num_smul_pipe #(
    parameter int LEFT_WIDTH  = 16,
    parameter int RIGHT_WIDTH = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_LSB     = 8,
    parameter int LATENCY     = 3,
    parameter int ROUND       = 1,
    parameter int SATURATE    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic signed [LEFT_WIDTH-1:0]  left,
    input  logic signed [RIGHT_WIDTH-1:0] right,
    output logic signed [OUT_WIDTH-1:0]   out,
    output logic                          ovf,
    output logic                          done
);

    localparam int PW = LEFT_WIDTH + RIGHT_WIDTH;
    localparam int HS = (OUT_LSB > 0) ? OUT_LSB - 1 : 0;
    localparam int HW = PW - OUT_WIDTH + 2;

    localparam logic signed [PW:0] HALF =
        (ROUND != 0 && OUT_LSB > 0) ? ({{PW{1'b0}}, 1'b1} << HS) : '0;

    localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    generate
        if (LATENCY < 2 || OUT_LSB + OUT_WIDTH > PW + 1) begin : g_bad_cfg
            $error("num_smul_pipe: bad LATENCY or output window");
        end
    endgenerate

    logic signed [LEFT_WIDTH-1:0]  a_q;
    logic signed [RIGHT_WIDTH-1:0] b_q;
    logic                          v1_q;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] prod_c;

    logic signed [PW-1:0] p_fin;
    logic                 v_fin;

    logic signed [PW:0]    p_ext;
    logic signed [PW:0]    r_c;
    logic [HW-1:0]         hi_c;
    logic                  fits_c;
    logic [OUT_WIDTH-1:0]  res_c;

    logic [OUT_WIDTH-1:0]  out_q;
    logic                  ovf_q;
    logic                  done_q;

    // Stage 1 valid bit: cleared by reset, follows go otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= go;
        end
    end

    // Stage 1 operands: only captured on go so idle cycles do not toggle.
    always_ff @(posedge clk) begin
        if (go) begin
            a_q <= left;
            b_q <= right;
        end
    end

    // Sign-extend to full product width so the multiply is exact.
    assign a_x    = {{RIGHT_WIDTH{a_q[LEFT_WIDTH-1]}}, a_q};
    assign b_x    = {{LEFT_WIDTH{b_q[RIGHT_WIDTH-1]}}, b_q};
    assign prod_c = a_x * b_x;

    generate
        if (LATENCY == 2) begin : g_l2
            // Product, rounding and clamping all land in the output stage.
            assign p_fin = prod_c;
            assign v_fin = v1_q;
        end else begin : g_pipe
            localparam int D = LATENCY - 2;

            logic signed [PW-1:0] p_q [D];
            logic [D-1:0]         pv_q;

            // Valid bits shift alongside the product; reset drops all.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    pv_q <= '0;
                end else begin
                    pv_q[0] <= v1_q;
                    for (int i = 1; i < D; i++) begin
                        pv_q[i] <= pv_q[i-1];
                    end
                end
            end

            // Product register followed by plain delay stages.
            always_ff @(posedge clk) begin
                if (v1_q) begin
                    p_q[0] <= prod_c;
                end
                for (int i = 1; i < D; i++) begin
                    if (pv_q[i-1]) begin
                        p_q[i] <= p_q[i-1];
                    end
                end
            end

            assign p_fin = p_q[D-1];
            assign v_fin = pv_q[D-1];
        end
    endgenerate

    // One extra bit keeps the rounding add from overflowing.
    assign p_ext = {p_fin[PW-1], p_fin};
    assign r_c   = (p_ext + HALF) >>> OUT_LSB;

    // Result fits when every bit above the output sign bit matches it.
    assign hi_c   = r_c[PW:OUT_WIDTH-1];
    assign fits_c = (hi_c == {HW{1'b0}}) || (hi_c == {HW{1'b1}});

    // Window selection with optional clamp to the signed output range.
    always_comb begin
        res_c = r_c[OUT_WIDTH-1:0];
        if (SATURATE != 0 && !fits_c) begin
            res_c = r_c[PW] ? MINV : MAXV;
        end
    end

    // Output stage: results hold between valid beats, done pulses once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= v_fin;
            if (v_fin) begin
                out_q <= res_c;
                ovf_q <= !fits_c;
            end
        end
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign done = done_q;

endmodule

// File: tb/tb_num_smul_pipe.sv
// tb_num_smul_pipe: directed and random checks of num_smul_pipe
// across rounding, saturation and latency variants.
module tb_num_smul_pipe;

    logic        clk;
    logic        reset;
    logic        go;
    logic [15:0] left;
    logic [15:0] right;

    logic [15:0] out_w  [5];
    logic        ovf_w  [5];
    logic        done_w [5];

    int errs;
    int checks;

    int          first_k [5];
    int          cnt     [5];
    logic [15:0] got_out [5];
    logic        got_ovf [5];

    logic [15:0] la [16];
    logic [15:0] ra [16];

    // 0: defaults, 1: ROUND=0, 2: SATURATE=0, 3: LATENCY=2, 4: LATENCY=5
    num_smul_pipe u_def (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out_w[0]), .ovf(ovf_w[0]), .done(done_w[0])
    );
    num_smul_pipe #(.ROUND(0)) u_r0 (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out_w[1]), .ovf(ovf_w[1]), .done(done_w[1])
    );
    num_smul_pipe #(.SATURATE(0)) u_s0 (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out_w[2]), .ovf(ovf_w[2]), .done(done_w[2])
    );
    num_smul_pipe #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out_w[3]), .ovf(ovf_w[3]), .done(done_w[3])
    );
    num_smul_pipe #(.LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out_w[4]), .ovf(ovf_w[4]), .done(done_w[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact product, optional +half, arithmetic shift, clamp/wrap.
    function automatic logic [16:0] ref_model(input logic [15:0] l,
                                              input logic [15:0] r,
                                              input bit rnd,
                                              input bit sat);
        longint a;
        longint b;
        longint p;
        bit     fits;
        logic [15:0] o;
        a = longint'($signed(l));
        b = longint'($signed(r));
        p = a * b;
        if (rnd) p = p + 128;
        p = p >>> 8;
        fits = (p >= -32768) && (p <= 32767);
        o = p[15:0];
        if (!fits && sat) o = (p < 0) ? 16'h8000 : 16'h7FFF;
        return {!fits, o};
    endfunction

    task automatic run_one(input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < 5; i++) begin
            first_k[i] = 0;
            cnt[i]     = 0;
            got_out[i] = '0;
            got_ovf[i] = 1'b0;
        end
        left  = l;
        right = r;
        go    = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            for (int i = 0; i < 5; i++) begin
                if (done_w[i]) begin
                    cnt[i]++;
                    if (first_k[i] == 0) begin
                        first_k[i] = k;
                        got_out[i] = out_w[i];
                        got_ovf[i] = ovf_w[i];
                    end
                end
            end
        end
    endtask

    task automatic run_pattern(input logic [15:0] gp, input int n);
        int q[$];
        int idx;
        logic [19:0] pat;
        pat = '0;
        for (int t = 0; t < n + 4; t++) begin
            go    = (t < n) ? gp[t] : 1'b0;
            left  = la[t % 16];
            right = ra[t % 16];
            if (go) q.push_back(t % 16);
            tick();
            pat[t] = done_w[0];
            if (done_w[0]) begin
                if (q.size() == 0) begin
                    chk("done_spurious", 32'd1, 32'd0);
                end else begin
                    idx = q.pop_front();
                    for (int j = 0; j < 3; j++) begin
                        chk($sformatf("res%0d_%0d", j, idx),
                            {15'd0, ovf_w[j], out_w[j]},
                            {15'd0, ref_model(la[idx], ra[idx],
                                              j != 1, j != 2)});
                    end
                end
            end
        end
        go = 1'b0;
        chk("done_pattern", 32'(pat), 32'(gp) << 2);
        chk("pending", q.size(), 32'd0);
    endtask

    initial begin
        int any_done;
        errs   = 0;
        checks = 0;
        reset  = 1'b0;
        go     = 1'b0;
        left   = '0;
        right  = '0;
        tick();
        tick();
        chk("rst_out", 32'(out_w[0]), 32'd0);
        chk("rst_ovf", 32'(ovf_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        reset = 1'b1;
        tick();

        // Basic Q8.8: 1.5 * 2.0 = 3.0, plus latency sweep.
        run_one(16'h0180, 16'h0200);
        chk("basic_out", 32'(got_out[0]), 32'h0300);
        chk("basic_ovf", 32'(got_ovf[0]), 32'd0);
        chk("basic_cnt", cnt[0], 32'd1);
        chk("lat3", first_k[0] + 1, 32'd3);
        chk("lat2", first_k[3] + 1, 32'd2);
        chk("lat5", first_k[4] + 1, 32'd5);
        chk("lat2_out", 32'(got_out[3]), 32'h0300);
        chk("lat5_out", 32'(got_out[4]), 32'h0300);
        chk("lat5_cnt", cnt[4], 32'd1);

        // Rounding at the half-LSB boundary.
        run_one(16'h0001, 16'h0080);
        chk("rnd_up", 32'(got_out[0]), 32'h0001);
        chk("rnd_trunc", 32'(got_out[1]), 32'h0000);
        run_one(16'hFFFF, 16'h0080);
        chk("rnd_neg", 32'(got_out[0]), 32'h0000);
        chk("trunc_neg", 32'(got_out[1]), 32'hFFFF);

        // Saturation and wrap.
        run_one(16'h7FFF, 16'h7FFF);
        chk("sat_max", 32'(got_out[0]), 32'h7FFF);
        chk("sat_max_ovf", 32'(got_ovf[0]), 32'd1);
        chk("wrap_out", 32'(got_out[2]), 32'hFF00);
        chk("wrap_ovf", 32'(got_ovf[2]), 32'd1);
        run_one(16'h8000, 16'h0200);
        chk("sat_min", 32'(got_out[0]), 32'h8000);
        chk("sat_min_ovf", 32'(got_ovf[0]), 32'd1);

        // Hold: outputs keep last value while idle.
        tick();
        chk("hold_out", 32'(out_w[0]), 32'h8000);

        // Throughput: four back-to-back, then 1,0,1.
        la[0] = 16'h0180; ra[0] = 16'h0200;
        la[1] = 16'h0100; ra[1] = 16'h0300;
        la[2] = 16'hFF00; ra[2] = 16'h0080;
        la[3] = 16'h0040; ra[3] = 16'h7FFF;
        for (int i = 4; i < 16; i++) begin
            la[i] = 16'h0000;
            ra[i] = 16'h0000;
        end
        run_pattern(16'h000F, 4);
        la[0] = 16'h0200; ra[0] = 16'h0200;
        la[1] = 16'h1234; ra[1] = 16'h4321;
        la[2] = 16'hFE80; ra[2] = 16'h0300;
        run_pattern(16'h0005, 3);

        // Reset mid-operation drops the in-flight product.
        left  = 16'h0180;
        right = 16'h0200;
        go    = 1'b1;
        tick();
        go    = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        any_done = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_w[0] || done_w[4]) any_done = 1;
        end
        chk("midrst_done", any_done, 32'd0);
        chk("midrst_out", 32'(out_w[0]), 32'd0);
        chk("midrst_ovf", 32'(ovf_w[0]), 32'd0);
        run_one(16'h0180, 16'h0200);
        chk("post_rst_lat", first_k[0] + 1, 32'd3);
        chk("post_rst_out", 32'(got_out[0]), 32'h0300);

        // Random signed vectors, full issue then sparse issue.
        for (int i = 0; i < 16; i++) begin
            la[i] = 16'($urandom());
            ra[i] = 16'($urandom());
        end
        la[0] = 16'h8000; ra[0] = 16'h8000;
        la[1] = 16'h8000; ra[1] = 16'h7FFF;
        run_pattern(16'hFFFF, 16);
        for (int i = 0; i < 16; i++) begin
            la[i] = 16'($urandom_range(0, 65535));
            ra[i] = 16'($urandom_range(0, 65535));
        end
        run_pattern(16'hB6D5, 16);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
